// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port block memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_e;

    // Port indices: instruction cache and data cache
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int unsigned DEF_ADDR_W      = 10;
    localparam int unsigned DEF_BLK_W       = 128;
    localparam int unsigned DEF_OFF_W       = 4;
    localparam int unsigned DEF_TIMEOUT_CYC = 64;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the port that did not
// win last time is chosen.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       sel
);

    // Pick the single requester, or the non-last one on a tie
    always_comb begin
        valid = |req;
        case (req)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~last;
            default: sel = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter_2p.sv
// Two-port arbiter sharing one block-wide memory port between the I-cache
// (port 0) and the D-cache (port 1). One transaction in flight at a time,
// round-robin between ports. Optional watchdog enabled by ARB_TIMEOUT_EN.
module mem_arbiter_2p
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned BLK_W       = DEF_BLK_W,
    parameter int unsigned OFF_W       = DEF_OFF_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [BLK_W-1:0]  wdata0,
    input  logic [BLK_W-1:0]  wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [BLK_W-1:0]  rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BLK_W-1:0]  mem_wdata,
    input  logic [BLK_W-1:0]  mem_rdata,
    input  logic              mem_ready
);

    arb_state_e        state_q, state_d;
    logic              sel_q, sel_d;
    logic              rw_q, rw_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BLK_W-1:0]  wdata_q, wdata_d;
    logic [BLK_W-1:0]  rdata_q, rdata_d;
    logic              pick_valid;
    logic              pick_sel;
    logic              timeout;

    rr_pick2 u_pick (
        .req   ({req1, req0}),
        .last  (last_q),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Final ISSUE cycle before the watchdog fires
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Watchdog: clear on grant, count ISSUE cycles, flag abort when mem_ready never came
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == IDLE && pick_valid) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (state_q == ISSUE) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!mem_ready && timeout) begin
                err_d = 1'b1;
            end
        end
    end

    // Watchdog registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q & (state_q == RESP);
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

    // Offset bits never reach memory
    logic unused_offset;
    assign unused_offset = ^{addr0[OFF_W-1:0], addr1[OFF_W-1:0]};

    // Next-state: grant and latch in IDLE, wait for memory in ISSUE, ack in RESP
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rw_d    = rw_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_sel;
                    rw_d    = pick_sel ? rw1 : rw0;
                    addr_d  = {(pick_sel ? addr1[ADDR_W-1:OFF_W] : addr0[ADDR_W-1:OFF_W]),
                               {OFF_W{1'b0}}};
                    wdata_d = pick_sel ? wdata1 : wdata0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // mem_ready beats the watchdog on the same edge
                if (mem_ready) begin
                    rdata_d = rw_q ? '0 : mem_rdata;
                    state_d = RESP;
                end else if (timeout) begin
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                last_d  = sel_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state registers; last grant resets to port D so port I wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= PORT_I;
            rw_q    <= 1'b0;
            last_q  <= PORT_D;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rw_q    <= rw_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_req   = (state_q == ISSUE);
    assign mem_rw    = rw_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign ack0      = (state_q == RESP) && (sel_q == PORT_I);
    assign ack1      = (state_q == RESP) && (sel_q == PORT_D);

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Scoreboard bench for mem_arbiter_2p: per-port expected queues filled at issue,
// a memory responder model, and a monitor that checks every ack.
module tb_mem_arbiter_2p;

    logic         clk;
    logic         rst_n;
    logic         req0, req1, rw0, rw1;
    logic [9:0]   addr0, addr1;
    logic [127:0] wdata0, wdata1;
    logic         ack0, ack1, err;
    logic [127:0] rdata;
    logic         mem_req, mem_rw, mem_ready;
    logic [9:0]   mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    typedef struct {
        logic         rw;
        logic [9:0]   maddr;
        logic [127:0] wd;
        logic [127:0] rd;
        logic         err;
    } exp_t;

    typedef struct {
        logic         rw;
        logic [9:0]   maddr;
        logic [127:0] wd;
    } mtx_t;

    exp_t         exp_q0[$];
    exp_t         exp_q1[$];
    mtx_t         mem_log[$];
    int           ack_order[$];
    logic [127:0] ref_mem[64];
    logic [127:0] mem_store[64];

    int n_cmp;
    int n_fail;
    int ready_delay;
    bit mem_silent;
    bit stray_en;

    mem_arbiter_2p #(
        .ADDR_W      (10),
        .BLK_W       (128),
        .OFF_W       (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .rw0       (rw0),
        .rw1       (rw1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] blk_init(input int i);
        if (i == 0) return '0;
        return {32'hC0DE0000 | 32'(i), 32'(i), 32'h12345678, 32'(i * 3)};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic drive(input int p, input logic rq, input logic rw, input logic [9:0] a,
                         input logic [127:0] wd);
        if (p == 0) begin
            req0 = rq; rw0 = rw; addr0 = a; wdata0 = wd;
        end else begin
            req1 = rq; rw1 = rw; addr1 = a; wdata1 = wd;
        end
    endtask

    // One requester transaction; expectation is pushed before the request is raised
    task automatic port_txn(input int p, input logic rw, input logic [9:0] a,
                            input logic [127:0] wd, input bit mutate, output int lat);
        exp_t e;
        bit   got;
        int   idx;
        idx     = int'(a[9:4]);
        e.rw    = rw;
        e.maddr = {a[9:4], 4'h0};
        e.wd    = wd;
        e.err   = 1'b0;
        if (rw) begin
            e.rd         = '0;
            ref_mem[idx] = wd;
        end else begin
            e.rd = ref_mem[idx];
        end
        if (p == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        @(posedge clk); #1;
        drive(p, 1'b1, rw, a, wd);
        lat = 0;
        got = 0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if ((p == 0) ? ack0 : ack1) got = 1;
            else if (mutate && mem_req) drive(p, 1'b1, ~rw, 10'h300, ~wd);
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_timeout_port%0d: got no ack want ack within 200 cycles", p);
        end
        @(posedge clk); #1;
        drive(p, 1'b0, 1'($urandom), 10'($urandom), {$urandom, $urandom, $urandom, $urandom});
    endtask

    // Asynchronous reset pulse placed mid-cycle
    task automatic pulse_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_req_async", mem_req, 1'b0);
        chk("rst_ack0", ack0, 1'b0);
        chk("rst_ack1", ack1, 1'b0);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Memory responder: random or fixed latency, checks transaction stability, logs completions
    initial begin : responder
        logic [9:0]   cap_addr;
        logic         cap_rw;
        logic [127:0] cap_wd;
        bit           busy;
        int           dly;
        mtx_t         m;
        mem_ready = 1'b0;
        mem_rdata = '0;
        busy      = 0;
        dly       = 0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!rst_n) begin
                busy = 0;
                continue;
            end
            if (mem_req) begin
                if (!busy) begin
                    busy     = 1;
                    cap_addr = mem_addr;
                    cap_rw   = mem_rw;
                    cap_wd   = mem_wdata;
                    dly      = (ready_delay >= 0) ? ready_delay : int'($urandom_range(0, 3));
                end else begin
                    chk("mem_addr_stable", mem_addr, cap_addr);
                    chk("mem_rw_stable", mem_rw, cap_rw);
                    chk("mem_wdata_stable", mem_wdata, cap_wd);
                end
                if (!mem_silent) begin
                    if (dly == 0) begin
                        mem_ready = 1'b1;
                        if (cap_rw) begin
                            mem_store[cap_addr[9:4]] = cap_wd;
                            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                        end else begin
                            mem_rdata = mem_store[cap_addr[9:4]];
                        end
                        m.rw    = cap_rw;
                        m.maddr = cap_addr;
                        m.wd    = cap_wd;
                        mem_log.push_back(m);
                        busy = 0;
                    end else begin
                        dly--;
                    end
                end
            end else begin
                busy = 0;
                if (stray_en && $urandom_range(0, 3) == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    end

    // Monitor: pops expectations on every ack, checks exclusivity, pulse width and round-robin
    initial begin : monitor
        int   p;
        int   must_next;
        bit   prev_ack;
        exp_t e;
        mtx_t m;
        must_next = -1;
        prev_ack  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                must_next = -1;
                prev_ack  = 0;
                continue;
            end
            if (ack0 && ack1) begin
                n_cmp++;
                n_fail++;
                $display("FAIL ack_exclusive: got ack0=1 ack1=1 want at most one");
            end
            if (ack0 || ack1) begin
                p = ack1 ? 1 : 0;
                chk("ack_one_cycle", 128'(prev_ack), 128'(0));
                if (must_next >= 0) chk("rr_order", 128'(p), 128'(must_next));
                ack_order.push_back(p);
                if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got ack on port %0d want no ack", p);
                end else begin
                    e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk("rdata", rdata, e.rd);
                    chk("err", err, e.err);
                    if (!e.err) begin
                        if (mem_log.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL mem_txn_missing: got no memory completion want one");
                        end else begin
                            m = mem_log.pop_front();
                            chk("mem_addr", m.maddr, e.maddr);
                            chk("mem_rw", m.rw, e.rw);
                            if (e.rw) chk("mem_wdata", m.wd, e.wd);
                        end
                    end
                end
                must_next = ((p == 0) ? req1 : req0) ? 1 - p : -1;
            end
            prev_ack = ack0 || ack1;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no end of test want end within time limit");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stim
        int lat;
        n_cmp       = 0;
        n_fail      = 0;
        ready_delay = -1;
        mem_silent  = 0;
        stray_en    = 0;
        rst_n       = 1'b0;
        req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i]   = blk_init(i);
            mem_store[i] = blk_init(i);
        end
        #22 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ack0", ack0, 1'b0);
        chk("reset_ack1", ack1, 1'b0);
        chk("reset_err", err, 1'b0);
        chk("reset_mem_req", mem_req, 1'b0);
        chk("reset_mem_rw", mem_rw, 1'b0);
        chk("reset_mem_addr", mem_addr, 10'h000);
        chk("reset_mem_wdata", mem_wdata, '0);
        chk("reset_rdata", rdata, '0);
        stray_en = 1;

        // Read of a zero block with memory ready after two extra cycles
        ready_delay = 2;
        port_txn(0, 1'b0, 10'h000, '0, 0, lat);
        chk("latency_delay2", 128'(lat), 128'(5));

        // Minimum latency
        ready_delay = 0;
        port_txn(0, 1'b0, 10'h012, '0, 0, lat);
        chk("latency_min", 128'(lat), 128'(3));

        // Unaligned write from the data cache
        ready_delay = 1;
        port_txn(1, 1'b1, 10'h20B, 128'hFF, 0, lat);

        // Request inputs change while in ISSUE; latched copy must hold
        ready_delay = 3;
        port_txn(1, 1'b0, 10'h20B, '0, 1, lat);

        // Reset mid-ISSUE: no ack, mem_req drops at once
        mem_silent = 1;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 10'h040, '0);
        lat = 0;
        while (!mem_req && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("pre_reset_mem_req", mem_req, 1'b1);
        pulse_reset();
        mem_silent  = 0;
        ready_delay = -1;

        // Two rounds of simultaneous requests: must alternate starting with port 0
        ack_order.delete();
        for (int r = 0; r < 2; r++) begin
            fork
                begin
                    int l0;
                    port_txn(0, 1'b0, 10'h0A0, '0, 0, l0);
                end
                begin
                    int l1;
                    port_txn(1, 1'b0, 10'h3C0, '0, 0, l1);
                end
            join
        end
        chk("tie_count", 128'(ack_order.size()), 128'(4));
        if (ack_order.size() == 4) begin
            chk("tie_grant0", 128'(ack_order[0]), 128'(0));
            chk("tie_grant1", 128'(ack_order[1]), 128'(1));
            chk("tie_grant2", 128'(ack_order[2]), 128'(0));
            chk("tie_grant3", 128'(ack_order[3]), 128'(1));
        end

        // Memory never answers
        mem_silent = 1;
`ifdef ARB_TIMEOUT_EN
        begin
            exp_t e;
            int   issue_cyc;
            bit   got;
            e.rw = 1'b0; e.maddr = 10'h050; e.wd = '0; e.rd = '0; e.err = 1'b1;
            exp_q0.push_back(e);
            @(posedge clk); #1;
            drive(0, 1'b1, 1'b0, 10'h05C, '0);
            issue_cyc = 0;
            got       = 0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                if (ack0) got = 1;
                else if (mem_req) issue_cyc++;
            end
            chk("timeout_ack", 128'(got), 128'(1));
            chk("timeout_issue_cycles", 128'(issue_cyc), 128'(8));
            @(posedge clk); #1;
            drive(0, 1'b0, 1'b0, '0, '0);
        end
`else
        begin
            bit saw_ack;
            bit saw_err;
            saw_ack = 0;
            saw_err = 0;
            @(posedge clk); #1;
            drive(0, 1'b1, 1'b0, 10'h05C, '0);
            repeat (100) begin
                @(negedge clk);
                if (ack0 || ack1) saw_ack = 1;
                if (err) saw_err = 1;
            end
            chk("no_ack_without_watchdog", 128'(saw_ack), 128'(0));
            chk("err_tied_low", 128'(saw_err), 128'(0));
            chk("stuck_mem_req", mem_req, 1'b1);
            pulse_reset();
        end
`endif
        mem_silent = 0;

        // Randomised traffic: port 0 reads blocks 0-31, port 1 reads/writes blocks 32-63
        fork
            begin
                int l0;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    port_txn(0, 1'b0, {1'b0, 9'($urandom)}, {$urandom, $urandom, $urandom,
                             $urandom}, 0, l0);
                end
            end
            begin
                int l1;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    port_txn(1, 1'($urandom), {1'b1, 9'($urandom)}, {$urandom, $urandom,
                             $urandom, $urandom}, 0, l1);
                end
            end
        join

        repeat (10) @(negedge clk);
        chk("exp_q0_drained", 128'(exp_q0.size()), 128'(0));
        chk("exp_q1_drained", 128'(exp_q1.size()), 128'(0));
        chk("mem_log_drained", 128'(mem_log.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
